alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle ALU for the datapath execute stage.
- Keeps all base integer ops at 1-cycle registered latency.
- Adds signed/unsigned compare and a true arithmetic right shift.
- Adds an iterative multiply/divide engine (RV-M semantics) behind a valid/ready handshake, so the core stalls only on M-ops.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_muldiv_iter.sv | 113 +++++++++++
 rtl/alu_mc.sv | 138 +++++++++++++
 tb/tb_alu_mc.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM types for the multi-cycle execute-stage ALU.
package alu_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_SLL    = 5'd4,
        OP_SLT    = 5'd5,
        OP_XOR    = 5'd6,
        OP_SRL    = 5'd7,
        OP_SRA    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div(input logic [ALU_OP_W-1:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply (shift-add) and restoring divide on operand magnitudes,
// one bit per cycle, with sign fix-up and short-circuited divide corner cases.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                done,
    output logic [WIDTH-1:0]    res
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic                 active;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 div_mode;
    logic                 neg_res;
    logic                 pick_hi;

    logic                 op_div;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 special;
    logic [WIDTH-1:0]     special_res;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   acc_nx;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     sel;
    logic [WIDTH-1:0]     iter_res;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        special     = 1'b0;
        special_res = '0;
        op_div      = is_div(op);
        a_neg       = a[WIDTH-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
        b_neg       = b[WIDTH-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        if (op_div && b == '0) begin
            special     = 1'b1;
            special_res = (op == OP_DIV || op == OP_DIVU) ? '1 : a;
        end else if ((op == OP_DIV || op == OP_REM) && a == MIN_VAL && b == '1) begin
            special     = 1'b1;
            special_res = (op == OP_DIV) ? MIN_VAL : '0;
        end
    end

    // acc holds {product hi, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, opnd};
        if (div_mode) begin
            acc_nx = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]), acc[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            acc_nx = {sum, acc[WIDTH-1:1]};
        end
        prod_fix = (neg_res && !div_mode) ? -acc_nx : acc_nx;
        sel      = pick_hi ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
        iter_res = (neg_res && div_mode) ? -sel : sel;
    end

    assign done = (start && special) || (active && count == '0);
    assign res  = (start && special) ? special_res : iter_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            active   <= 1'b0;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            neg_res  <= 1'b0;
            pick_hi  <= 1'b0;
        end else if (flush) begin
            active <= 1'b0;
            count  <= '0;
        end else if (start && !special) begin
            active   <= 1'b1;
            count    <= CW'(WIDTH - 1);
            div_mode <= op_div;
            pick_hi  <= op_div ? (op == OP_REM || op == OP_REMU) : (op != OP_MUL);
            neg_res  <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
            acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
            opnd     <= op_div ? b_mag : a_mag;
        end else if (active) begin
            acc <= acc_nx;
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle registered base ops plus an optional
// iterative M-extension engine behind valid/ready handshakes.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    src_a,
    input  logic [WIDTH-1:0]    src_b,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                busy
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state;
    state_e           state_nx;
    logic             out_valid_nx;
    logic [WIDTH-1:0] result_nx;
    logic [WIDTH-1:0] base_res;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             md_op;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_res;

    assign shamt    = src_b[SHW-1:0];
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign md_op    = (MULDIV_EN != 0) && is_muldiv(alu_op);
    assign md_start = accept && md_op;
    assign busy     = (state != IDLE);

    always_comb begin
        base_res = '0;
        case (alu_op)
            OP_ADD:  base_res = src_a + src_b;
            OP_SUB:  base_res = src_a - src_b;
            OP_AND:  base_res = src_a & src_b;
            OP_OR:   base_res = src_a | src_b;
            OP_XOR:  base_res = src_a ^ src_b;
            OP_SLL:  base_res = src_a << shamt;
            OP_SRL:  base_res = src_a >> shamt;
            OP_SRA:  base_res = $signed(src_a) >>> shamt;
            OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            default: base_res = '0;
        endcase
    end

    generate
        if (MULDIV_EN != 0) begin : g_md
            alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (flush),
                .start (md_start),
                .op    (alu_op),
                .a     (src_a),
                .b     (src_b),
                .done  (md_done),
                .res   (md_res)
            );
        end else begin : g_no_md
            assign md_done = 1'b0;
            assign md_res  = '0;
        end
    endgenerate

    always_comb begin
        state_nx     = state;
        out_valid_nx = out_valid;
        result_nx    = result;
        if (flush) begin
            state_nx     = IDLE;
            out_valid_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) out_valid_nx = 1'b0;
                    if (accept) begin
                        if (!md_op) begin
                            out_valid_nx = 1'b1;
                            result_nx    = base_res;
                        end else if (md_done) begin
                            // Divide corner cases resolve without iterating.
                            state_nx     = DONE;
                            out_valid_nx = 1'b1;
                            result_nx    = md_res;
                        end else begin
                            state_nx = is_div(alu_op) ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    if (md_done) begin
                        state_nx     = DONE;
                        out_valid_nx = 1'b1;
                        result_nx    = md_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx     = IDLE;
                        out_valid_nx = 1'b0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            state     <= state_nx;
            out_valid <= out_valid_nx;
            result    <= result_nx;
            zero      <= (result_nx == '0);
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int M_LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic [4:0]    alu_op = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero;
    logic          busy;

    int total = 0;
    int bad = 0;

    alu_mc #(.WIDTH(W), .MULDIV_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .alu_op    (alu_op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int          ia;
        int          ib;
        logic [4:0]  sh;
        logic [63:0] p;
        ia = a;
        ib = b;
        sh = b[4:0];
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a << sh;
            5'd5:  return (ia < ib) ? 32'd1 : 32'd0;
            5'd6:  return a ^ b;
            5'd7:  return a >> sh;
            5'd8:  return 32'(ia >>> sh);
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd10: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            5'd11: begin p = 64'(longint'(ia) * longint'(ib)); return p[63:32]; end
            5'd12: begin p = 64'(longint'(ia) * longint'({32'h0, b})); return p[63:32]; end
            5'd13: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            5'd14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            5'd17: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 5'd10 || op > 5'd17) return 1;
        if (op >= 5'd14 && b == 0) return 1;
        if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return M_LAT;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Offer one op, then count cycles until out_valid and compare everything.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        check({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        alu_op   = op;
        src_a    = a;
        src_b    = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (lat <= 100 && !out_valid) begin
            if (lat == 2) begin
                check({tag, ".busy"}, busy, 1);
                check({tag, ".in_ready_busy"}, in_ready, 0);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".result"}, result, exp);
        check({tag, ".zero"}, zero, (exp == 0));
    endtask

    initial begin
        logic [31:0] exp;
        logic [31:0] held;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cnt;

        repeat (2) @(negedge clk);
        check("rst.out_valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.zero", zero, 1);
        check("rst.busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", in_ready, 1);

        run_op("add_wrap", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
        run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 32'h0, 1);
        run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("sra", OP_SRA, 32'h8000_0000, 32'd33, 32'hC000_0000, 1);
        run_op("srl", OP_SRL, 32'h8000_0000, 32'd33, 32'h4000_0000, 1);
        run_op("bad_op", 5'd18, 32'h1234, 32'h5678, 32'h0, 1);
        run_op("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, M_LAT);
        run_op("mulhu", OP_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, M_LAT);
        run_op("mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, M_LAT);
        run_op("divu_0", OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_0", OP_REM, 32'd7, 32'd0, 32'd7, 1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, M_LAT);
        run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, M_LAT);

        // Back-to-back base ops: one accepted per cycle.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            op = 5'($urandom_range(0, 9));
            a = rand_operand();
            b = rand_operand();
            check("b2b.in_ready", in_ready, 1);
            in_valid = 1'b1;
            alu_op = op;
            src_a = a;
            src_b = b;
            exp = ref_model(op, a, b);
            @(posedge clk);
            @(negedge clk);
            check("b2b.out_valid", out_valid, 1);
            check("b2b.result", result, exp);
        end
        in_valid = 1'b0;

        // Backpressure on a finished multiply.
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        in_valid = 1'b1;
        alu_op = OP_MULHSU;
        src_a = a;
        src_b = b;
        exp = ref_model(OP_MULHSU, a, b);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        cnt = 1;
        while (cnt <= 100 && !out_valid) begin
            @(negedge clk);
            cnt++;
        end
        check("bp.lat", cnt, M_LAT);
        in_valid = 1'b1;
        alu_op = OP_ADD;
        src_a = 32'd1;
        src_b = 32'd1;
        for (int k = 0; k < 5; k++) begin
            check("bp.result", result, exp);
            check("bp.out_valid", out_valid, 1);
            check("bp.in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.release_valid", out_valid, 0);
        check("bp.release_busy", busy, 0);
        check("bp.release_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.next_valid", out_valid, 1);
        check("bp.next_result", result, 32'd2);

        // Async reset in the middle of a divide.
        @(negedge clk);
        in_valid = 1'b1;
        alu_op = OP_DIVU;
        src_a = 32'd1000;
        src_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("arst.busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", out_valid, 0);
        check("arst.busy", busy, 0);
        check("arst.zero", zero, 1);
        check("arst.result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_after_rst", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

        // Flush in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1;
        alu_op = OP_MUL;
        src_a = 32'd12345;
        src_b = 32'd678;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy", busy, 0);
        check("flush.out_valid", out_valid, 0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        check("flush.no_result", cnt, 0);

        // Flush wins over a simultaneous offer.
        in_valid = 1'b1;
        alu_op = OP_ADD;
        src_a = 32'd9;
        src_b = 32'd9;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_prio.out_valid", out_valid, 0);
        check("flush_prio.busy", busy, 0);

        for (int i = 0; i < 200; i++) begin
            op = 5'($urandom_range(0, 19));
            a = rand_operand();
            b = rand_operand();
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_model(op, a, b), ref_latency(op, a, b));
        end

        held = result;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
